// File: rtl/program_load_packer.sv
// Packs a host word stream into 64-byte program-RAM lines and issues each line as one aw + one w beat.
// Optional RAM-reset phase before filling: define PROG_LOAD_RAM_RESET_EN.
module program_load_packer #(
`ifdef PROG_LOAD_RAM_RESET_EN
    parameter int RAMRST_CYCLES = 4,
`endif
    parameter int IN_W   = 64,
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 13
) (
    input  logic              io_axiClk,
    input  logic              io_asyncReset,
`ifdef PROG_LOAD_RAM_RESET_EN
    output logic              program_load_ram_reset,
`endif
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [CNT_W-1:0]  cfg_word_count,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [IN_W-1:0]   s_data,
    output logic              program_load_en,
    output logic              program_load_aw_valid,
    input  logic              program_load_aw_ready,
    output logic [ADDR_W-1:0] program_load_aw_payload_addr,
    output logic              program_load_w_valid,
    input  logic              program_load_w_ready,
    output logic [511:0]      program_load_w_payload_data,
    output logic [63:0]       program_load_w_payload_strb,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);
    localparam int WPL   = 512 / IN_W;
    localparam int BPW   = IN_W / 8;
    localparam int IDX_W = (WPL > 1) ? $clog2(WPL) : 1;
    // Wide enough that base + count*BPW can never wrap, so any overflow rejects.
    localparam int SUM_W = ADDR_W + CNT_W + 1;

    typedef enum logic [2:0] {
        IDLE, FILL, ISSUE, DONE
`ifdef PROG_LOAD_RAM_RESET_EN
        , RAMRST
`endif
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] line_addr;
    logic [CNT_W-1:0]  remaining;
    logic [IDX_W-1:0]  idx;
    logic [511:0]      data_q;
    logic [63:0]       strb_q;
    logic [SUM_W-1:0]  end_addr;
    logic              start_ok;
    logic              aw_fin;
    logic              w_fin;

`ifdef PROG_LOAD_RAM_RESET_EN
    localparam int RC_W = $clog2(RAMRST_CYCLES + 1);
    logic [RC_W-1:0] ramrst_cnt;
    assign program_load_ram_reset = (state == RAMRST);
    assign busy = (state == FILL) || (state == ISSUE) || (state == RAMRST);
`else
    assign busy = (state == FILL) || (state == ISSUE);
`endif

    assign program_load_en = busy;
    assign done            = (state == DONE);
    assign s_ready         = (state == FILL);

    assign program_load_aw_payload_addr = line_addr;
    assign program_load_w_payload_data  = data_q;
    assign program_load_w_payload_strb  = strb_q;

    assign end_addr = SUM_W'(cfg_base_addr) + SUM_W'(cfg_word_count) * SUM_W'(BPW);
    assign start_ok = (cfg_base_addr[5:0] == 6'd0) && (cfg_word_count != '0) &&
                      (end_addr <= (SUM_W'(1) << ADDR_W));

    // A channel counts as finished once its valid is already low or handshakes this cycle.
    assign aw_fin = !program_load_aw_valid || program_load_aw_ready;
    assign w_fin  = !program_load_w_valid  || program_load_w_ready;

    always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            state                 <= IDLE;
            line_addr             <= '0;
            remaining             <= '0;
            idx                   <= '0;
            data_q                <= '0;
            strb_q                <= '0;
            program_load_aw_valid <= 1'b0;
            program_load_w_valid  <= 1'b0;
            cfg_err               <= 1'b0;
`ifdef PROG_LOAD_RAM_RESET_EN
            ramrst_cnt            <= '0;
`endif
        end else begin
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        if (start_ok) begin
                            line_addr <= cfg_base_addr;
                            remaining <= cfg_word_count;
`ifdef PROG_LOAD_RAM_RESET_EN
                            ramrst_cnt <= '0;
                            state      <= RAMRST;
`else
                            state      <= FILL;
`endif
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
`ifdef PROG_LOAD_RAM_RESET_EN
                RAMRST: begin
                    ramrst_cnt <= ramrst_cnt + 1'b1;
                    if (ramrst_cnt == RC_W'(RAMRST_CYCLES - 1))
                        state <= FILL;
                end
`endif
                FILL: begin
                    if (s_valid) begin
                        data_q[idx*IN_W +: IN_W] <= s_data;
                        strb_q[idx*BPW +: BPW]   <= '1;
                        idx                      <= idx + 1'b1;
                        remaining                <= remaining - 1'b1;
                        if (idx == IDX_W'(WPL - 1) || remaining == CNT_W'(1)) begin
                            state                 <= ISSUE;
                            program_load_aw_valid <= 1'b1;
                            program_load_w_valid  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (program_load_aw_ready) program_load_aw_valid <= 1'b0;
                    if (program_load_w_ready)  program_load_w_valid  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        line_addr <= line_addr + ADDR_W'(64);
                        data_q    <= '0;
                        strb_q    <= '0;
                        idx       <= '0;
                        state     <= (remaining != '0) ? FILL : DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_load_packer.sv
// Randomized self-checking bench for program_load_packer; expected lines come from a word-list model.
module tb_program_load_packer;
`ifdef PROG_LOAD_RAM_RESET_EN
    localparam int RR = 4;
`else
    localparam int RR = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_start = 1'b0;
    logic [14:0]  cfg_base_addr = '0;
    logic [12:0]  cfg_word_count = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [63:0]  s_data = '0;
    logic         program_load_en;
    logic         program_load_aw_valid;
    logic         program_load_aw_ready = 1'b1;
    logic [14:0]  program_load_aw_payload_addr;
    logic         program_load_w_valid;
    logic         program_load_w_ready = 1'b1;
    logic [511:0] program_load_w_payload_data;
    logic [63:0]  program_load_w_payload_strb;
    logic         busy;
    logic         done;
    logic         cfg_err;
`ifdef PROG_LOAD_RAM_RESET_EN
    logic         program_load_ram_reset;
`endif

    int checks = 0;
    int errors = 0;
    int stab_err = 0;

    logic [63:0]  words[$];
    logic [14:0]  got_a[$];
    logic [511:0] got_d[$];
    logic [63:0]  got_s[$];
    logic [14:0]  exp_a[$];
    logic [511:0] exp_d[$];
    logic [63:0]  exp_s[$];

    program_load_packer dut (
        .io_axiClk                    (clk),
        .io_asyncReset                (rst),
`ifdef PROG_LOAD_RAM_RESET_EN
        .program_load_ram_reset       (program_load_ram_reset),
`endif
        .cfg_start                    (cfg_start),
        .cfg_base_addr                (cfg_base_addr),
        .cfg_word_count               (cfg_word_count),
        .s_valid                      (s_valid),
        .s_ready                      (s_ready),
        .s_data                       (s_data),
        .program_load_en              (program_load_en),
        .program_load_aw_valid        (program_load_aw_valid),
        .program_load_aw_ready        (program_load_aw_ready),
        .program_load_aw_payload_addr (program_load_aw_payload_addr),
        .program_load_w_valid         (program_load_w_valid),
        .program_load_w_ready         (program_load_w_ready),
        .program_load_w_payload_data  (program_load_w_payload_data),
        .program_load_w_payload_strb  (program_load_w_payload_strb),
        .busy                         (busy),
        .done                         (done),
        .cfg_err                      (cfg_err)
    );

    always #5 clk = ~clk;

    // Handshake monitor: record completed beats and catch payload changes while stalled.
    logic         prev_aw_stall = 1'b0;
    logic         prev_w_stall  = 1'b0;
    logic [14:0]  prev_addr;
    logic [511:0] prev_data;
    logic [63:0]  prev_strb;
    always @(negedge clk) begin
        if (program_load_aw_valid && program_load_aw_ready) got_a.push_back(program_load_aw_payload_addr);
        if (program_load_w_valid && program_load_w_ready) begin
            got_d.push_back(program_load_w_payload_data);
            got_s.push_back(program_load_w_payload_strb);
        end
        if (prev_aw_stall && program_load_aw_valid && program_load_aw_payload_addr !== prev_addr) stab_err++;
        if (prev_w_stall && program_load_w_valid &&
            (program_load_w_payload_data !== prev_data || program_load_w_payload_strb !== prev_strb)) stab_err++;
        prev_aw_stall = program_load_aw_valid && !program_load_aw_ready;
        prev_w_stall  = program_load_w_valid && !program_load_w_ready;
        prev_addr = program_load_aw_payload_addr;
        prev_data = program_load_w_payload_data;
        prev_strb = program_load_w_payload_strb;
    end

    // Reference model: word i lands in line i/8, slot i%8; lines are consecutive 64B blocks.
    task automatic model_lines(input logic [14:0] base);
        logic [511:0] d;
        logic [63:0]  s;
        exp_a.delete(); exp_d.delete(); exp_s.delete();
        for (int l = 0; l * 8 < words.size(); l++) begin
            d = '0;
            s = '0;
            for (int k = 0; k < 8; k++) begin
                if (l * 8 + k < words.size()) begin
                    d[k*64 +: 64] = words[l*8 + k];
                    s[k*8 +: 8]   = 8'hFF;
                end
            end
            exp_a.push_back(base + 15'(l * 64));
            exp_d.push_back(d);
            exp_s.push_back(s);
        end
    endtask

    task automatic clear_got();
        got_a.delete(); got_d.delete(); got_s.delete();
    endtask

    task automatic do_start(input logic [14:0] b, input logic [12:0] c);
        cfg_start = 1'b1;
        cfg_base_addr = b;
        cfg_word_count = c;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    // Feeds words[wi0..] until done or budget; cycle 1 is the cycle right after the start edge.
    task automatic drive_until_done(input int wi0, input bit rnd, output bit got_done,
                                    output int done_cyc, output bit en_ok);
        int wi;
        int cyc;
        wi = wi0;
        cyc = 1;
        got_done = 1'b0;
        done_cyc = 0;
        en_ok = 1'b1;
        while (!got_done && cyc <= 3000) begin
            s_valid = (wi < words.size()) && (!rnd || $urandom_range(0, 3) != 0);
            s_data  = (wi < words.size()) ? words[wi] : 64'd0;
            program_load_aw_ready = !rnd || $urandom_range(0, 1) == 1;
            program_load_w_ready  = !rnd || $urandom_range(0, 1) == 1;
            @(negedge clk);
            if (s_valid && s_ready) wi++;
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                if (program_load_en !== 1'b0 || busy !== 1'b0) en_ok = 1'b0;
            end else if (program_load_en !== 1'b1 || busy !== 1'b1) begin
                en_ok = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        program_load_aw_ready = 1'b1;
        program_load_w_ready  = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({s_ready, program_load_en, program_load_aw_valid, program_load_w_valid, busy, done, cfg_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b required=0000000", {s_ready, program_load_en, program_load_aw_valid,
                     program_load_w_valid, busy, done, cfg_err});
        end
        checks++;
        if (program_load_aw_payload_addr !== 15'd0 || program_load_w_payload_data !== '0 ||
            program_load_w_payload_strb !== 64'd0) begin
            errors++;
            $display("FAIL reset_payload addr=%h strb=%h required=0", program_load_aw_payload_addr,
                     program_load_w_payload_strb);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Full line, partial last line and the top-of-RAM boundary, with fixed word values 1..N.
    task automatic test_directed_loads();
        logic [14:0] bases[3]  = '{15'h0000, 15'h0040, 15'h7FC0};
        logic [12:0] counts[3] = '{13'd8, 13'd11, 13'd8};
        bit gd;
        int dc;
        bit eo;
        for (int t = 0; t < 3; t++) begin
            words.delete();
            for (int i = 0; i < int'(counts[t]); i++) words.push_back(64'(i + 1));
            model_lines(bases[t]);
            clear_got();
            do_start(bases[t], counts[t]);
            drive_until_done(0, 1'b0, gd, dc, eo);
            checks++;
            if (!gd) begin errors++; $display("FAIL dir%0d done_timeout", t); end
            checks++;
            if (!eo) begin errors++; $display("FAIL dir%0d en_busy_profile got=bad required=held_then_dropped", t); end
            checks++;
            if (got_a.size() != exp_a.size() || got_d.size() != exp_a.size()) begin
                errors++;
                $display("FAIL dir%0d line_count aw=%0d w=%0d required=%0d", t, got_a.size(), got_d.size(), exp_a.size());
            end
            for (int i = 0; i < exp_a.size() && i < got_a.size() && i < got_d.size(); i++) begin
                checks++;
                if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i] || got_s[i] !== exp_s[i]) begin
                    errors++;
                    $display("FAIL dir%0d line%0d addr=%h/%h strb=%h/%h data=%h required=%h", t, i,
                             got_a[i], exp_a[i], got_s[i], exp_s[i], got_d[i], exp_d[i]);
                end
            end
            if (t == 0 && got_d.size() > 0) begin
                checks++;
                if (dc != 10 + RR) begin errors++; $display("FAIL full_line_latency got=%0d required=%0d", dc, 10 + RR); end
                checks++;
                if (got_d[0][63:0] !== 64'd1 || got_d[0][511:448] !== 64'd8 || got_s[0] !== {64{1'b1}}) begin
                    errors++;
                    $display("FAIL full_line_slots lo=%h hi=%h strb=%h required=1/8/all-ones",
                             got_d[0][63:0], got_d[0][511:448], got_s[0]);
                end
            end
            if (t == 1 && got_d.size() > 1) begin
                checks++;
                if (got_a[1] !== 15'h0080 || got_s[1] !== 64'h0000_0000_00FF_FFFF || got_d[1][511:192] !== '0) begin
                    errors++;
                    $display("FAIL partial_tail addr=%h strb=%h required=0080/0000000000ffffff upper_zero=%0d",
                             got_a[1], got_s[1], got_d[1][511:192] === '0);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        bit ok;
        logic [511:0] d0;
        int wi;
        bit gd;
        int dc;
        bit eo;
        words.delete();
        for (int i = 0; i < 16; i++) words.push_back({$urandom, $urandom});
        model_lines(15'h0400);
        clear_got();
        stab_err = 0;
        do_start(15'h0400, 13'd16);
        program_load_aw_ready = 1'b1;
        program_load_w_ready  = 1'b0;
        wi = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            s_valid = 1'b1;
            s_data  = words[wi];
            @(negedge clk);
            if (s_valid && s_ready) wi++;
            if (program_load_w_valid) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!seen || program_load_aw_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_issue_entry seen=%0d aw_valid=%b required=1/1", seen, program_load_aw_valid);
        end
        d0 = program_load_w_payload_data;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            s_valid = 1'b1;
            s_data  = words[wi];
            if (k == 5) program_load_w_ready = 1'b1;
            @(negedge clk);
            ok = program_load_aw_valid === 1'b0 && program_load_w_valid === 1'b1 &&
                 program_load_w_payload_data === d0 && s_ready === 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL bp_stall_c%0d aw_v=%b w_v=%b s_ready=%b data_held=%0d required=0/1/0/1", k,
                         program_load_aw_valid, program_load_w_valid, s_ready, program_load_w_payload_data === d0);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || program_load_w_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_resume s_ready=%b w_valid=%b required=1/0", s_ready, program_load_w_valid);
        end
        if (s_valid && s_ready) wi++;
        @(posedge clk); #1;
        drive_until_done(wi, 1'b0, gd, dc, eo);
        checks++;
        if (!gd || got_d.size() != 2 || got_a.size() != 2) begin
            errors++;
            $display("FAIL bp_lines done=%0d aw=%0d w=%0d required=1/2/2", gd, got_a.size(), got_d.size());
        end else begin
            checks++;
            if (got_a[0] !== exp_a[0] || got_a[1] !== exp_a[1] || got_d[0] !== exp_d[0] || got_d[1] !== exp_d[1]) begin
                errors++;
                $display("FAIL bp_content addr0=%h addr1=%h required=%h/%h", got_a[0], got_a[1], exp_a[0], exp_a[1]);
            end
        end
        checks++;
        if (stab_err != 0) begin errors++; $display("FAIL bp_payload_stability got=%0d required=0", stab_err); end
    endtask

    task automatic test_reject();
        logic [14:0] bases[4]  = '{15'h0004, 15'h0000, 15'h7FC0, 15'h7FC0};
        logic [12:0] counts[4] = '{13'd1, 13'd0, 13'd9, 13'd8191};
        logic [14:0] b;
        logic [12:0] c;
        bit exp_ok;
        for (int t = 0; t < 4; t++) begin
            do_start(bases[t], counts[t]);
            @(negedge clk);
            checks++;
            if (cfg_err !== 1'b1 || busy !== 1'b0 || program_load_en !== 1'b0) begin
                errors++;
                $display("FAIL reject%0d cfg_err=%b busy=%b en=%b required=1/0/0", t, cfg_err, busy, program_load_en);
            end
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (cfg_err !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reject%0d_pulse cfg_err=%b busy=%b required=0/0", t, cfg_err, busy);
            end
            @(posedge clk); #1;
        end
        for (int t = 0; t < 8; t++) begin
            b = 15'($urandom_range(0, 32767));
            if ($urandom_range(0, 1) == 1) b[5:0] = 6'd0;
            c = 13'($urandom_range(0, 4200));
            exp_ok = (int'(b) % 64 == 0) && (c != 0) && (int'(b) + int'(c) * 8 <= 32768);
            do_start(b, c);
            @(negedge clk);
            checks++;
            if (cfg_err !== !exp_ok || busy !== exp_ok) begin
                errors++;
                $display("FAIL rand_start b=%h c=%0d cfg_err=%b busy=%b required=%b/%b", b, c, cfg_err, busy,
                         !exp_ok, exp_ok);
            end
            rst = 1'b1;
            #2;
            rst = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random_loads();
        logic [14:0] b;
        bit gd;
        int dc;
        bit eo;
        stab_err = 0;
        for (int t = 0; t < 6; t++) begin
            b = 15'($urandom_range(0, 500) * 64);
            words.delete();
            for (int i = 0; i < int'($urandom_range(1, 40)); i++) words.push_back({$urandom, $urandom});
            model_lines(b);
            clear_got();
            do_start(b, 13'(words.size()));
            drive_until_done(0, 1'b1, gd, dc, eo);
            checks++;
            if (!gd || !eo) begin errors++; $display("FAIL rand%0d done=%0d en_ok=%0d required=1/1", t, gd, eo); end
            checks++;
            if (got_a.size() != exp_a.size() || got_d.size() != exp_a.size()) begin
                errors++;
                $display("FAIL rand%0d line_count aw=%0d w=%0d required=%0d", t, got_a.size(), got_d.size(), exp_a.size());
            end
            for (int i = 0; i < exp_a.size() && i < got_a.size() && i < got_d.size(); i++) begin
                checks++;
                if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i] || got_s[i] !== exp_s[i]) begin
                    errors++;
                    $display("FAIL rand%0d line%0d addr=%h/%h strb=%h/%h data=%h required=%h", t, i,
                             got_a[i], exp_a[i], got_s[i], exp_s[i], got_d[i], exp_d[i]);
                end
            end
        end
        checks++;
        if (stab_err != 0) begin errors++; $display("FAIL rand_payload_stability got=%0d required=0", stab_err); end
    endtask

    task automatic test_reset_mid_issue();
        bit seen;
        int wi;
        bit gd;
        int dc;
        bit eo;
        words.delete();
        for (int i = 0; i < 8; i++) words.push_back({$urandom, $urandom});
        clear_got();
        do_start(15'h0200, 13'd8);
        program_load_aw_ready = 1'b0;
        program_load_w_ready  = 1'b0;
        wi = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            s_valid = wi < 8;
            s_data  = (wi < 8) ? words[wi] : 64'd0;
            @(negedge clk);
            if (s_valid && s_ready) wi++;
            if (program_load_aw_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("FAIL rst_mid_issue_entry seen=0 required=1"); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({program_load_aw_valid, program_load_w_valid, program_load_en, busy} !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid_issue_abort got=%b required=0000",
                     {program_load_aw_valid, program_load_w_valid, program_load_en, busy});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        program_load_aw_ready = 1'b1;
        program_load_w_ready  = 1'b1;
        words.delete();
        for (int i = 0; i < 5; i++) words.push_back({$urandom, $urandom});
        model_lines(15'h1000);
        clear_got();
        do_start(15'h1000, 13'd5);
        drive_until_done(0, 1'b0, gd, dc, eo);
        checks++;
        if (!gd || got_a.size() != 1 || got_d.size() != 1) begin
            errors++;
            $display("FAIL rst_reload done=%0d aw=%0d w=%0d required=1/1/1", gd, got_a.size(), got_d.size());
        end else begin
            checks++;
            if (got_a[0] !== exp_a[0] || got_d[0] !== exp_d[0] || got_s[0] !== exp_s[0]) begin
                errors++;
                $display("FAIL rst_reload_line addr=%h/%h strb=%h/%h", got_a[0], exp_a[0], got_s[0], exp_s[0]);
            end
        end
    endtask

`ifdef PROG_LOAD_RAM_RESET_EN
    task automatic test_ramrst();
        bit gd;
        int dc;
        bit eo;
        words.delete();
        for (int i = 0; i < 8; i++) words.push_back({$urandom, $urandom});
        clear_got();
        do_start(15'h0000, 13'd8);
        for (int k = 1; k <= RR + 1; k++) begin
            @(negedge clk);
            checks++;
            if (program_load_ram_reset !== (k <= RR) || program_load_en !== 1'b1 || s_ready !== (k > RR)) begin
                errors++;
                $display("FAIL ramrst_c%0d ram_reset=%b en=%b s_ready=%b required=%b/1/%b", k,
                         program_load_ram_reset, program_load_en, s_ready, k <= RR, k > RR);
            end
            @(posedge clk); #1;
        end
        drive_until_done(0, 1'b0, gd, dc, eo);
        checks++;
        if (!gd || got_d.size() != 1) begin
            errors++;
            $display("FAIL ramrst_load done=%0d lines=%0d required=1/1", gd, got_d.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed_loads();
        test_backpressure();
        test_reject();
        test_random_loads();
        test_reset_mid_issue();
`ifdef PROG_LOAD_RAM_RESET_EN
        test_ramrst();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
